// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: halt word, memory
// geometry and the loader state encoding.
package imem_pkg;

  localparam logic [15:0] HALT_WORD  = 16'hFFFF;
  localparam int          IMEM_DEPTH = 1024;
  localparam int          IMEM_AW    = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_WR    = 3'd3,
    ST_CK_HI = 3'd4,
    ST_CK_LO = 3'd5,
    ST_DONE  = 3'd6
  } ld_state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Byte-to-word assembler: offers byte_ready while the loader is in a high or
// low byte slot and captures accepted bytes into a 16-bit word (high byte
// first).
module imem_word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel_hi,
  input  logic        sel_lo,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        hi_xfer,
  output logic        lo_xfer,
  output logic [15:0] word
);

  logic [15:0] word_q, word_d;

  // Handshake decode and byte placement into the word being assembled.
  always_comb begin
    byte_ready = sel_hi | sel_lo;
    hi_xfer    = sel_hi & byte_valid;
    lo_xfer    = sel_lo & byte_valid;
    word_d     = word_q;
    if (hi_xfer) word_d[15:8] = byte_data;
    if (lo_xfer) word_d[7:0]  = byte_data;
  end

  // Word register; a partially assembled word is dropped on reset.
  always_ff @(posedge clock) begin
    if (reset) word_q <= '0;
    else       word_q <= word_d;
  end

  assign word = word_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a byte stream into 16-bit imem writes and
// holds the CPU until the halt word is stored or memory fills up.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum
// word after the halt word, compared against the sum of all written words.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [15:0]        imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               overflow,
  output logic [CNT_W-1:0]   word_count,
  output logic               checksum_err
);

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             sel_hi, sel_lo, hi_xfer, lo_xfer;
  logic [15:0]      word;
  logic [IMEM_AW-1:0] addr_ext;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic        ck_err_q, ck_err_d;
`endif

  imem_word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .sel_hi     (sel_hi),
    .sel_lo     (sel_lo),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .hi_xfer    (hi_xfer),
    .lo_xfer    (lo_xfer),
    .word       (word)
  );

  // Next-state, counter and status update; outputs decoded from state.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
    ck_err_d = ck_err_q;
    sel_hi   = (state_q == ST_HI) || (state_q == ST_CK_HI);
    sel_lo   = (state_q == ST_LO) || (state_q == ST_CK_LO);
`else
    sel_hi   = (state_q == ST_HI);
    sel_lo   = (state_q == ST_LO);
`endif
    imem_we  = (state_q == ST_WR);
    done     = (state_q == ST_DONE);
    cpu_hold = (state_q != ST_IDLE) && (state_q != ST_DONE);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_HI;
          count_d = '0;
          ovf_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d    = '0;
          ck_err_d = 1'b0;
`endif
        end
      end
      ST_HI: if (hi_xfer) state_d = ST_LO;
      ST_LO: if (lo_xfer) state_d = ST_WR;
      ST_WR: begin
        count_d = count_q + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q + word;
`endif
        if (word == HALT_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = ST_CK_HI;
`else
          state_d = ST_DONE;
`endif
        end else if (count_q + CNT_W'(1) == CNT_W'(DEPTH)) begin
          state_d = ST_DONE;
          ovf_d   = 1'b1;
        end else begin
          state_d = ST_HI;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CK_HI: if (hi_xfer) state_d = ST_CK_LO;
      ST_CK_LO: begin
        if (lo_xfer) begin
          ck_err_d = ({word[15:8], byte_data} != sum_q);
          state_d  = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running checksum of written words and the comparison result.
  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q    <= '0;
      ck_err_q <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      ck_err_q <= ck_err_d;
    end
  end
  assign checksum_err = ck_err_q;
`else
  assign checksum_err = 1'b0;
`endif

  // imem is addressed in bytes; each word occupies two.
  assign addr_ext   = IMEM_AW'(count_q);
  assign imem_addr  = addr_ext << 1;
  assign imem_wdata = word;
  assign word_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader, built with a 4-word memory so the overflow
// and last-slot cases are reachable quickly.
module tb_imem_loader;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset, start, byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready, imem_we, cpu_hold, done, overflow, checksum_err;
  logic [15:0]      imem_addr, imem_wdata;
  logic [CNT_W-1:0] word_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [15:0] exp_w[4];

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .overflow     (overflow),
    .word_count   (word_count),
    .checksum_err (checksum_err)
  );

  always #5 clock = ~clock;

  // Record every imem write seen between clock edges.
  always @(negedge clock) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge following the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit tog);
    int n;
    byte_data = b;
    for (int g = 0; g < gap; g++) begin
      byte_valid = tog & ~byte_ready & g[0];
      @(negedge clock);
    end
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("hs_wait", 32'(n < 20), 32'd1);
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_byte(w[15:8], gap, 1'b1);
    send_byte(w[7:0], gap, 1'b1);
  endtask

  // Trailing checksum word, only present when the feature is built in.
  task automatic maybe_ck(input logic [15:0] s);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(s, 0);
`endif
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("done_wait", 32'(n < 20), 32'd1);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_log(input string tag, input int n);
    chk({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < wr_addr_q.size()) begin
        chk({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(i * 2));
        chk({tag, "_data"}, 32'(wr_data_q[i]), 32'(exp_w[i]));
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    do_reset();

    // Reset state
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ckerr", 32'(checksum_err), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);

    // Basic three-word program ending in the halt word
    exp_w = '{16'h710F, 16'h7207, 16'hFFFF, 16'h0000};
    clear_log();
    pulse_start();
    chk("t1_hold_on", 32'(cpu_hold), 32'd1);
    chk("t1_ready_on", 32'(byte_ready), 32'd1);
    send_word(16'h710F, 0);
    send_word(16'h7207, 0);
    send_word(16'hFFFF, 0);
    maybe_ck(16'hE315);
    wait_done();
    check_log("t1", 3);
    chk("t1_count", 32'(word_count), 32'd3);
    chk("t1_hold_off", 32'(cpu_hold), 32'd0);
    chk("t1_ovf", 32'(overflow), 32'd0);
    chk("t1_ckerr", 32'(checksum_err), 32'd0);

    // Same stream with gaps and valid toggling while not ready
    clear_log();
    pulse_start();
    chk("t2_count_clr", 32'(word_count), 32'd0);
    chk("t2_done_clr", 32'(done), 32'd0);
    send_byte(8'h71, 1, 1'b1);
    send_byte(8'h0F, 3, 1'b1);
    send_byte(8'h72, 2, 1'b1);
    send_byte(8'h07, 0, 1'b1);
    send_byte(8'hFF, 3, 1'b1);
    send_byte(8'hFF, 2, 1'b1);
    maybe_ck(16'hE315);
    wait_done();
    repeat (3) @(negedge clock);
    check_log("t2", 3);
    chk("t2_count", 32'(word_count), 32'd3);

    // Overflow: four non-halt words fill the memory
    exp_w = '{16'h1000, 16'h2001, 16'h3002, 16'h4003};
    clear_log();
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(exp_w[i], i % 2);
    wait_done();
    check_log("t3", 4);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_count", 32'(word_count), 32'd4);
    byte_data = 8'h55;
    byte_valid = 1'b1;
    repeat (4) @(negedge clock);
    chk("t3_no_accept", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    chk("t3_nwr_after", 32'(wr_addr_q.size()), 32'd4);
    chk("t3_count_sat", 32'(word_count), 32'd4);

    // Halt word in the last slot: done without overflow
    exp_w = '{16'h0102, 16'h0304, 16'h0506, 16'hFFFF};
    clear_log();
    pulse_start();
    chk("t3b_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) send_word(exp_w[i], 0);
    maybe_ck(16'h090B);
    wait_done();
    check_log("t3b", 4);
    chk("t3b_ovf", 32'(overflow), 32'd0);
    chk("t3b_count", 32'(word_count), 32'd4);

    // Reset mid-load, then reload from address 0
    clear_log();
    pulse_start();
    send_word(16'h710F, 0);
    send_byte(8'h72, 0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    chk("t4_ready", 32'(byte_ready), 32'd0);
    chk("t4_hold", 32'(cpu_hold), 32'd0);
    chk("t4_count", 32'(word_count), 32'd0);
    chk("t4_we", 32'(imem_we), 32'd0);
    chk("t4_nwr", 32'(wr_addr_q.size()), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    exp_w = '{16'h1111, 16'hFFFF, 16'h0000, 16'h0000};
    clear_log();
    pulse_start();
    send_word(16'h1111, 0);
    send_word(16'hFFFF, 0);
    maybe_ck(16'h1110);
    wait_done();
    check_log("t4r", 2);

    // start during LO is ignored
    exp_w = '{16'h710F, 16'h7207, 16'hFFFF, 16'h0000};
    clear_log();
    pulse_start();
    send_byte(8'h71, 0, 1'b0);
    pulse_start();
    chk("t5_ready", 32'(byte_ready), 32'd1);
    chk("t5_count", 32'(word_count), 32'd0);
    send_byte(8'h0F, 0, 1'b0);
    send_word(16'h7207, 0);
    send_word(16'hFFFF, 0);
    maybe_ck(16'hE315);
    wait_done();
    check_log("t5", 3);
    chk("t5_count_end", 32'(word_count), 32'd3);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good and bad
    exp_w = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0000};
    clear_log();
    pulse_start();
    send_word(16'h0001, 0);
    send_word(16'hFFFF, 0);
    chk("t6_not_done", 32'(done), 32'd0);
    send_word(16'h0000, 0);
    wait_done();
    check_log("t6a", 2);
    chk("t6a_ckerr", 32'(checksum_err), 32'd0);
    clear_log();
    pulse_start();
    send_word(16'h0001, 0);
    send_word(16'hFFFF, 0);
    send_word(16'h1234, 0);
    wait_done();
    check_log("t6b", 2);
    chk("t6b_ckerr", 32'(checksum_err), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
